// File: rtl/arith_pkg.sv
// Shared constants and types for the arithmetic result path.
// The op tags label which arithmetic operation produced a buffered result.
package arith_pkg;

    localparam int RESULT_WIDTH = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/arith_flags.sv
// Purely combinational zero/negative flag derivation for a two's-complement result.
module arith_flags
    import arith_pkg::*;
#(
    parameter int WIDTH = RESULT_WIDTH
) (
    input  logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg
);

    assign zero = (result == '0);
    assign neg  = result[WIDTH-1];

endmodule

// File: rtl/arith_result_buffer.sv
// Two-entry in-order skid buffer for arithmetic results, carrying the op tag and
// zero/neg flags captured at push time.
module arith_result_buffer
    import arith_pkg::*;
#(
    parameter int WIDTH = RESULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic [1:0]       level
);

    buf_state_t       r_state;
    buf_state_t       w_nextState;
    logic             r_head;
    logic             w_wrIdx;
    logic             w_push;
    logic             w_pop;
    logic             w_zero;
    logic             w_neg;

    logic [WIDTH-1:0] r_result [2];
    logic [1:0]       r_op     [2];
    logic             r_zero   [2];
    logic             r_neg    [2];

    arith_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .result (in_result),
        .zero   (w_zero),
        .neg    (w_neg)
    );

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // An empty buffer writes into the head slot so the entry is visible next cycle;
    // otherwise the free slot is always the one opposite the head.
    assign w_wrIdx = (r_state == EMPTY) ? r_head : ~r_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY: if (w_push) w_nextState = ONE;
            ONE: begin
                if (w_push && !w_pop)      w_nextState = FULL;
                else if (w_pop && !w_push) w_nextState = EMPTY;
            end
            FULL: if (w_pop) w_nextState = ONE;
            default: w_nextState = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (r_state != FULL) && !rst;
        out_valid = (r_state != EMPTY);
        case (r_state)
            ONE:     level = 2'd1;
            FULL:    level = 2'd2;
            default: level = 2'd0;
        endcase
        out_result = out_valid ? r_result[r_head] : '0;
        out_op     = out_valid ? r_op[r_head]     : 2'b00;
        out_zero   = out_valid ? r_zero[r_head]   : 1'b0;
        out_neg    = out_valid ? r_neg[r_head]    : 1'b0;
    end

    // A simultaneous push and pop in ONE writes the opposite slot and flips the head
    // onto it, so the new entry becomes head in a single edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_result[i] <= '0;
                r_op[i]     <= 2'b00;
                r_zero[i]   <= 1'b0;
                r_neg[i]    <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_result[w_wrIdx] <= in_result;
                r_op[w_wrIdx]     <= in_op;
                r_zero[w_wrIdx]   <= w_zero;
                r_neg[w_wrIdx]    <= w_neg;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

endmodule
